// File: rtl/pseudo_spi_xfer_engine.sv
// rtl/pseudo_spi_xfer_engine.sv - SRAM-to-serial transfer engine with two-phase shift clocks
//
// Fetches DATA_LEN words from SRAM starting at ADDR_BGN, shifts each word out on
// SPI_SO under non-overlapping SCLK1/SCLK2 phases of FREQ_DIV+1 cycles, then
// closes the frame with a LAT pulse.
//
// Optional feature macro: PSEUDO_SPI_RDBK_EN
//   Adds SPI_SI/RDBK; with RDBK latched high, returned bits are captured into the
//   shift register and written back to the same SRAM word (WRBK state).
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   BGN               start strobe (accepted in IDLE/DONE only)
//   ADDR_BGN          first SRAM address
//   DATA_LEN          number of words (0 completes immediately)
//   FREQ_DIV          phase length - 1, in CLK cycles
//   PI                SRAM read data
//   A, CEN, WEN, PO   SRAM address, chip enable (low), write enable (low), write data
//   SCLK1, SCLK2      phase-1 / phase-2 shift clocks
//   SPI_SO            serial data out
//   LAT               frame latch strobe
//   BUSY, DONE        status
//   SPI_SI, RDBK      read-back data in and enable (PSEUDO_SPI_RDBK_EN only)

module pseudo_spi_xfer_engine #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 9,
    parameter int LEN_W     = 8,
    parameter int DIV_W     = 8,
    parameter int ADDR_DEC  = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BGN,
    input  logic [ADDR_W-1:0] ADDR_BGN,
    input  logic [LEN_W-1:0]  DATA_LEN,
    input  logic [DIV_W-1:0]  FREQ_DIV,
    input  logic [DATA_W-1:0] PI,
`ifdef PSEUDO_SPI_RDBK_EN
    input  logic              SPI_SI,
    input  logic              RDBK,
`endif
    output logic [ADDR_W-1:0] A,
    output logic              CEN,
    output logic              WEN,
    output logic [DATA_W-1:0] PO,
    output logic              SCLK1,
    output logic              SCLK2,
    output logic              SPI_SO,
    output logic              LAT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_SHIFT = 3'd3,
`ifdef PSEUDO_SPI_RDBK_EN
        S_WRBK  = 3'd4,
`endif
        S_NEXT  = 3'd5,
        S_LATCH = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    cnt;
    logic [DIV_W-1:0]    div;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          phase;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shreg;

    logic [ADDR_W-1:0]   a_q;
    logic                cen_q;
    logic                sclk1_q;
    logic                sclk2_q;
    logic                so_q;
    logic                lat_q;
    logic                busy_q;
    logic                done_q;

    logic                si_bit;
    logic [DATA_W-1:0]   sh_next;
    logic                so_next;
    logic                first_bit;
    logic [ADDR_W-1:0]   addr_step;
    logic                phase_end;

`ifdef PSEUDO_SPI_RDBK_EN
    logic                rdbk_q;
    logic                wen_q;
    logic [DATA_W-1:0]   po_q;

    assign si_bit = rdbk_q & SPI_SI;
    assign WEN    = wen_q;
    assign PO     = po_q;
`else
    assign si_bit = 1'b0;
    assign WEN    = 1'b1;
    assign PO     = '0;
`endif

    // Shifting out of one end frees the other end for the returned bit, so the
    // first returned bit ends up in the same position as the first sent bit.
    assign sh_next   = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], si_bit}
                                        : {si_bit, shreg[DATA_W-1:1]};
    assign so_next   = (MSB_FIRST != 0) ? shreg[DATA_W-2] : shreg[1];
    assign first_bit = (MSB_FIRST != 0) ? PI[DATA_W-1] : PI[0];
    assign addr_step = (ADDR_DEC != 0) ? addr - 1'b1 : addr + 1'b1;
    assign phase_end = (div_cnt == div);

    assign A      = a_q;
    assign CEN    = cen_q;
    assign SCLK1  = sclk1_q;
    assign SCLK2  = sclk2_q;
    assign SPI_SO = so_q;
    assign LAT    = lat_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            addr    <= '0;
            cnt     <= '0;
            div     <= '0;
            div_cnt <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            a_q     <= '0;
            cen_q   <= 1'b1;
            sclk1_q <= 1'b0;
            sclk2_q <= 1'b0;
            so_q    <= 1'b0;
            lat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PSEUDO_SPI_RDBK_EN
            rdbk_q  <= 1'b0;
            wen_q   <= 1'b1;
            po_q    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (BGN) begin
                        addr    <= ADDR_BGN;
                        cnt     <= DATA_LEN;
                        div     <= FREQ_DIV;
                        div_cnt <= '0;
                        phase   <= '0;
                        bit_cnt <= '0;
`ifdef PSEUDO_SPI_RDBK_EN
                        rdbk_q  <= RDBK;
`endif
                        if (DATA_LEN == '0) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= S_ADDR;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            cen_q  <= 1'b0;
                            a_q    <= ADDR_BGN;
                        end
                    end
                end

                S_ADDR: begin
                    state <= S_READ;
                    cen_q <= 1'b1;
                    a_q   <= '0;
                end

                // PI carries the word addressed in S_ADDR during this cycle.
                S_READ: begin
                    state   <= S_SHIFT;
                    shreg   <= PI;
                    so_q    <= first_bit;
                    div_cnt <= '0;
                    phase   <= '0;
                    bit_cnt <= '0;
                end

                S_SHIFT: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        phase   <= phase + 2'd1;
                        sclk1_q <= (phase == 2'd0);
                        sclk2_q <= (phase == 2'd2);
                        // End of P3: the returned bit is taken on this edge and
                        // the next bit is presented for the coming P0.
                        if (phase == 2'd3) begin
                            shreg <= sh_next;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                so_q    <= 1'b0;
`ifdef PSEUDO_SPI_RDBK_EN
                                if (rdbk_q) begin
                                    state <= S_WRBK;
                                    cen_q <= 1'b0;
                                    wen_q <= 1'b0;
                                    a_q   <= addr;
                                    po_q  <= sh_next;
                                end else begin
                                    state <= S_NEXT;
                                end
`else
                                state <= S_NEXT;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                so_q    <= so_next;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

`ifdef PSEUDO_SPI_RDBK_EN
                S_WRBK: begin
                    state <= S_NEXT;
                    cen_q <= 1'b1;
                    wen_q <= 1'b1;
                    a_q   <= '0;
                    po_q  <= '0;
                end
`endif

                S_NEXT: begin
                    addr <= addr_step;
                    cnt  <= cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state   <= S_LATCH;
                        lat_q   <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        state <= S_ADDR;
                        cen_q <= 1'b0;
                        a_q   <= addr_step;
                    end
                end

                S_LATCH: begin
                    if (phase_end) begin
                        state   <= S_DONE;
                        lat_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pseudo_spi_xfer_engine.sv
// tb/tb_pseudo_spi_xfer_engine.sv - self-checking bench for pseudo_spi_xfer_engine

module tb_pseudo_spi_xfer_engine;

    localparam int DW        = 8;
    localparam int AW        = 9;
    localparam int LW        = 8;
    localparam int VW        = 8;
    localparam int ADDR_DEC  = 1;
    localparam int MSB_FIRST = 0;

    localparam logic [24:0] RST_VEC = {9'd0, 1'b1, 1'b1, 8'd0, 6'd0};

    logic          clk = 1'b0;
    logic          rst;
    logic          bgn;
    logic [AW-1:0] addr_bgn;
    logic [LW-1:0] data_len;
    logic [VW-1:0] freq_div;
    logic [DW-1:0] pi;
    logic          spi_si;
    logic          rdbk_in;
    logic [AW-1:0] a;
    logic          cen;
    logic          wen;
    logic [DW-1:0] po;
    logic          sclk1;
    logic          sclk2;
    logic          spi_so;
    logic          lat;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_a;
    logic [DW-1:0] bd_d;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] si_plan [$];

    always #5 clk = ~clk;

    pseudo_spi_xfer_engine #(
        .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .DIV_W(VW),
        .ADDR_DEC(ADDR_DEC), .MSB_FIRST(MSB_FIRST)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .BGN(bgn),
        .ADDR_BGN(addr_bgn),
        .DATA_LEN(data_len),
        .FREQ_DIV(freq_div),
        .PI(pi),
`ifdef PSEUDO_SPI_RDBK_EN
        .SPI_SI(spi_si),
        .RDBK(rdbk_in),
`endif
        .A(a),
        .CEN(cen),
        .WEN(wen),
        .PO(po),
        .SCLK1(sclk1),
        .SCLK2(sclk2),
        .SPI_SO(spi_so),
        .LAT(lat),
        .BUSY(busy),
        .DONE(done)
    );

    // Synchronous SRAM with a back door for preloading.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_a] <= bd_d;
        end else if (!cen) begin
            if (!wen) mem[a] <= po;
            else      pi     <= mem[a];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] out_vec();
        return {7'd0, a, cen, wen, po, sclk1, sclk2, spi_so, lat, busy, done};
    endfunction

    function automatic int bpos(input int b);
        return (MSB_FIRST != 0) ? DW - 1 - b : b;
    endfunction

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] start, input int i);
        return (ADDR_DEC != 0) ? start - AW'(i) : start + AW'(i);
    endfunction

    task automatic bd_write(input logic [AW-1:0] ad, input logic [DW-1:0] d);
        @(negedge clk);
        bd_we = 1'b1;
        bd_a  = ad;
        bd_d  = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Runs one frame, observing the bus every cycle, and compares against a model
    // built from the SRAM snapshot and the frame parameters.
    task automatic run_frame(input logic [AW-1:0] start, input int len, input int d,
                             input logic rb, input int pulse_at, input string name);
        logic [AW-1:0] exp_a [$];
        logic [DW-1:0] exp_w [$];
        logic [DW-1:0] si_w [$];
        logic [AW-1:0] got_rd [$];
        logic [AW-1:0] got_wa [$];
        logic          got_b [$];
        logic [DW-1:0] gw;
        logic [DW-1:0] si_cur;
        logic          p_s1, p_s2, p_so, seen_hi, done_flag;
        int exp_cycles, cycles, lat_cyc, overlap, werr, gerr, soerr, berr, bus_err;
        int r1, r2, gap, rises1, wi;

        for (int i = 0; i < len; i++) begin
            exp_a.push_back(word_addr(start, i));
            exp_w.push_back(mem[word_addr(start, i)]);
            if (si_plan.size() > 0) si_w.push_back(si_plan.pop_front());
            else                    si_w.push_back(DW'($urandom));
        end
        si_plan.delete();

        exp_cycles = (len == 0) ? 1
                   : 1 + len * (3 + 4 * DW * (d + 1)) + (d + 1) + (rb ? len : 0);

        cycles = 0; lat_cyc = 0; overlap = 0; werr = 0; gerr = 0; soerr = 0;
        berr = 0; bus_err = 0; r1 = 0; r2 = 0; gap = 0; rises1 = 0;
        p_s1 = 1'b0; p_s2 = 1'b0; p_so = spi_so; seen_hi = 1'b0; done_flag = 1'b0;

        @(negedge clk);
        addr_bgn = start;
        data_len = LW'(len);
        freq_div = VW'(d);
        rdbk_in  = rb;
        bgn      = 1'b1;

        while (!done_flag && cycles < exp_cycles + 64) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                bgn      = 1'b0;
                addr_bgn = AW'($urandom);
                data_len = LW'($urandom);
                freq_div = VW'($urandom);
                rdbk_in  = ~rb;
            end
            if (pulse_at > 0 && cycles == pulse_at)     bgn = 1'b1;
            if (pulse_at > 0 && cycles == pulse_at + 1) bgn = 1'b0;

            if (!cen && wen)  got_rd.push_back(a);
            if (!cen && !wen) got_wa.push_back(a);
            if (cen && a != '0) bus_err++;
            if (wen && po != '0) bus_err++;
            if (sclk1 && sclk2) overlap++;
            if (lat) lat_cyc++;
            if (len != 0 && !done && !busy) berr++;
            if (spi_so !== p_so && (sclk1 || sclk2 || p_s1)) soerr++;

            if (sclk1) r1++;
            else if (p_s1) begin
                if (r1 != d + 1) werr++;
                r1 = 0;
            end
            if (sclk2) r2++;
            else if (p_s2) begin
                if (r2 != d + 1) werr++;
                r2 = 0;
            end

            if (sclk1 && !p_s1) begin
                got_b.push_back(spi_so);
                if (seen_hi && (rises1 % DW) != 0 && gap != d + 1) gerr++;
                wi = rises1 / DW;
                if (wi < len) begin
                    si_cur = si_w[wi];
                    spi_si = si_cur[bpos(rises1 % DW)];
                end
                rises1++;
            end
            if (sclk2 && !p_s2 && gap != d + 1) gerr++;
            if (sclk1 || sclk2) begin
                seen_hi = 1'b1;
                gap     = 0;
            end else begin
                gap++;
            end

            p_s1      = sclk1;
            p_s2      = sclk2;
            p_so      = spi_so;
            done_flag = done;
        end

        check_eq($sformatf("%s_cycles", name), cycles, exp_cycles);
        check_eq($sformatf("%s_done", name), done, 1);
        check_eq($sformatf("%s_busy_end", name), busy, 0);
        check_eq($sformatf("%s_rd_count", name), got_rd.size(), len);
        for (int i = 0; i < len; i++) begin
            if (i < got_rd.size())
                check_eq($sformatf("%s_rd_addr%0d", name, i), got_rd[i], exp_a[i]);
            gw = 'x;
            for (int b = 0; b < DW; b++)
                if (i * DW + b < got_b.size()) gw[bpos(b)] = got_b[i * DW + b];
            check_eq($sformatf("%s_so_word%0d", name, i), gw, exp_w[i]);
            check_eq($sformatf("%s_mem%0d", name, i), mem[exp_a[i]], rb ? si_w[i] : exp_w[i]);
        end
        check_eq($sformatf("%s_bit_count", name), got_b.size(), len * DW);
        check_eq($sformatf("%s_wr_count", name), got_wa.size(), rb ? len : 0);
        check_eq($sformatf("%s_lat_cycles", name), lat_cyc, (len == 0) ? 0 : d + 1);
        check_eq($sformatf("%s_overlap", name), overlap, 0);
        check_eq($sformatf("%s_width_err", name), werr, 0);
        check_eq($sformatf("%s_gap_err", name), gerr, 0);
        check_eq($sformatf("%s_so_change_err", name), soerr, 0);
        check_eq($sformatf("%s_busy_err", name), berr, 0);
        check_eq($sformatf("%s_idle_bus_err", name), bus_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bgn = 1'b0; addr_bgn = '0; data_len = '0; freq_div = '0;
        rdbk_in = 1'b0; spi_si = 1'b0; bd_we = 1'b0; bd_a = '0; bd_d = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", out_vec(), 32'(RST_VEC));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_outputs", out_vec(), 32'(RST_VEC));

        bd_write(9'h010, 8'hA5);
        bd_write(9'h00F, 8'h3C);
        run_frame(9'h010, 2, 0, 1'b0, 0, "basic");
        run_frame(9'h010, 1, 3, 1'b0, 0, "timing");
        run_frame(9'h123, 0, 2, 1'b0, 0, "zero_len");

        bd_write(9'h000, 8'h81);
        bd_write(9'h1FF, 8'h7E);
        run_frame(9'h000, 2, 0, 1'b0, 0, "wrap");

        bd_write(9'h040, 8'h3F);
        bd_write(9'h03F, 8'hC2);
        run_frame(9'h040, 2, 1, 1'b0, 20, "busy_bgn");

        // Abort during bit 5 of the second word, then restart.
        @(negedge clk);
        addr_bgn = 9'h010; data_len = 8'd2; freq_div = 8'd0; rdbk_in = 1'b0; bgn = 1'b1;
        @(posedge clk);
        #1 bgn = 1'b0;
        repeat (58) @(posedge clk);
        #1;
        check_eq("busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1 check_eq("reset_midframe", out_vec(), 32'(RST_VEC));
        @(posedge clk);
        #1 check_eq("reset_held", out_vec(), 32'(RST_VEC));
        @(negedge clk);
        rst = 1'b0;
        run_frame(9'h010, 2, 0, 1'b0, 0, "restart");

        for (int k = 0; k < 6; k++) begin
            logic [AW-1:0] st;
            int ln, dv;
            logic rbr;
            st = AW'($urandom);
            ln = $urandom_range(1, 3);
            dv = $urandom_range(0, 2);
`ifdef PSEUDO_SPI_RDBK_EN
            rbr = 1'($urandom);
`else
            rbr = 1'b0;
`endif
            for (int i = 0; i < ln; i++) bd_write(word_addr(st, i), DW'($urandom));
            run_frame(st, ln, dv, rbr, 0, $sformatf("rand%0d", k));
        end

`ifdef PSEUDO_SPI_RDBK_EN
        bd_write(9'h010, 8'hA5);
        si_plan.push_back(8'h5A);
        run_frame(9'h010, 1, 0, 1'b1, 0, "rdbk");

        // Reset during the write-back cycle must leave the SRAM word untouched.
        begin
            int wait_cyc;
            bd_write(9'h020, 8'h66);
            spi_si = 1'b1;
            @(negedge clk);
            addr_bgn = 9'h020; data_len = 8'd1; freq_div = 8'd0; rdbk_in = 1'b1; bgn = 1'b1;
            wait_cyc = 0;
            do begin
                @(posedge clk);
                #1;
                bgn = 1'b0;
                wait_cyc++;
            end while (!(cen == 1'b0 && wen == 1'b0) && wait_cyc < 100);
            check_eq("wrbk_reached", wait_cyc < 100, 1);
            #2 rst = 1'b1;
            @(posedge clk);
            #1 check_eq("wrbk_abort_mem", mem[9'h020], 8'h66);
            @(negedge clk);
            rst = 1'b0;
        end
        run_frame(9'h020, 1, 1, 1'b1, 0, "rdbk_restart");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
